// File: rtl/sdp_addsub_pipe_pkg.sv
// Shared types and arithmetic for the sdp add/sub pipeline.
// sdp_addsub works on sign-extended operands so one function serves every width W < SDP_MAX_W.
package sdp_pkg;

   localparam logic SDP_OP_ADD = 1'b1;
   localparam logic SDP_OP_SUB = 1'b0;
   localparam int unsigned SDP_MAX_W = 64;

   // Returns {ovf, result}; only result[w-1:0] is meaningful.
   function automatic logic [SDP_MAX_W:0] sdp_addsub(input logic [SDP_MAX_W-1:0] acc,
                                                     input logic [SDP_MAX_W-1:0] op,
                                                     input logic              add,
                                                     input logic              sat,
                                                     input int unsigned       w);
      logic signed [SDP_MAX_W:0] a_s;
      logic signed [SDP_MAX_W:0] o_s;
      logic signed [SDP_MAX_W:0] sum;
      logic signed [SDP_MAX_W:0] max_v;
      logic signed [SDP_MAX_W:0] min_v;
      logic                      ovf;
      logic [SDP_MAX_W-1:0]      res;
      a_s   = signed'({acc[SDP_MAX_W-1], acc});
      o_s   = signed'({op[SDP_MAX_W-1], op});
      sum   = (add == SDP_OP_ADD) ? a_s + o_s : a_s - o_s;
      max_v = (65'sd1 <<< (w - 1)) - 65'sd1;
      min_v = -max_v - 65'sd1;
      ovf   = (sum > max_v) || (sum < min_v);
      if (sat && ovf) begin
         res = sum[SDP_MAX_W] ? min_v[SDP_MAX_W-1:0] : max_v[SDP_MAX_W-1:0];
      end else begin
         res = sum[SDP_MAX_W-1:0];
      end
      return {ovf, res};
   endfunction

endpackage

// File: rtl/sdp_addsub_pipe_if.sv
// Valid/ready bus of the sdp add/sub pipeline: input transaction side and result side.
interface sdp_addsub_pipe_if #(
   parameter int unsigned W    = 8,
   parameter int unsigned NOPS = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [NOPS-1:0]   in_ctl;
   logic [W-1:0]      in_a;
   logic [NOPS*W-1:0] in_ops;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic              out_ovf;

   modport master (
      output in_valid, in_ctl, in_a, in_ops, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_ctl, in_a, in_ops, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/sdp_addsub_pipe_stage.sv
// One elastic add/sub stage: applies operand 0 under ctl bit 0, shifts the rest down by one slot.
module sdp_addsub_stage
   import sdp_pkg::*;
#(
   parameter int unsigned W        = 8,
   parameter int unsigned NOPS     = 2,
   parameter bit          SATURATE = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_acc,
   input  logic [NOPS*W-1:0] in_ops,
   input  logic [NOPS-1:0]   in_ctl,
   input  logic              in_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_acc,
   output logic [NOPS*W-1:0] out_ops,
   output logic [NOPS-1:0]   out_ctl,
   output logic              out_ovf
);
   logic              valid_q;
   logic [W-1:0]      acc_q;
   logic [NOPS*W-1:0] ops_q;
   logic [NOPS-1:0]   ctl_q;
   logic              ovf_q;
   logic [SDP_MAX_W:0] calc;
   logic              unused_calc;

   always_comb begin
      calc = sdp_addsub(SDP_MAX_W'(signed'(in_acc)), SDP_MAX_W'(signed'(in_ops[W-1:0])),
                        in_ctl[0], SATURATE, W);
   end
   assign unused_calc = ^calc;

   assign in_ready = !valid_q || out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         acc_q   <= '0;
         ops_q   <= '0;
         ctl_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (in_ready) begin
         valid_q <= in_valid;
         if (in_valid) begin
            acc_q <= calc[W-1:0];
            ops_q <= in_ops >> W;
            ctl_q <= in_ctl >> 1;
            ovf_q <= in_ovf | calc[SDP_MAX_W];
         end
      end
   end

   assign out_valid = valid_q;
   assign out_acc   = acc_q;
   assign out_ops   = ops_q;
   assign out_ctl   = ctl_q;
   assign out_ovf   = ovf_q;
endmodule

// File: rtl/sdp_addsub_pipe.sv
// Elastic add/sub pipeline: capture register followed by NOPS arithmetic stages.
// Latency NOPS+1, one transaction per cycle, combinational ready chain so bubbles collapse.
module sdp_addsub_pipe
   import sdp_pkg::*;
#(
   parameter int unsigned W        = 8,
   parameter int unsigned NOPS     = 2,
   parameter bit          SATURATE = 1'b0
) (
   input logic              clk,
   input logic              reset,
   sdp_addsub_pipe_if.slave bus
);
   logic              v0_q;
   logic [W-1:0]      a0_q;
   logic [NOPS*W-1:0] ops0_q;
   logic [NOPS-1:0]   ctl0_q;
   logic              in_ready;

   logic [NOPS:0]     vld;
   logic [NOPS:0]     dn_rdy;
   logic [NOPS:1]     up_rdy;
   logic [NOPS:0]     ovf;
   logic [W-1:0]      acc [NOPS+1];
   logic [NOPS*W-1:0] ops [NOPS+1];
   logic [NOPS-1:0]   ctl [NOPS+1];
   logic              unused_tail;

   always_ff @(posedge clk) begin
      if (reset) begin
         v0_q   <= 1'b0;
         a0_q   <= '0;
         ops0_q <= '0;
         ctl0_q <= '0;
      end else if (in_ready) begin
         v0_q <= bus.in_valid;
         if (bus.in_valid) begin
            a0_q   <= bus.in_a;
            ops0_q <= bus.in_ops;
            ctl0_q <= bus.in_ctl;
         end
      end
   end

   assign vld[0] = v0_q;
   assign acc[0] = a0_q;
   assign ops[0] = ops0_q;
   assign ctl[0] = ctl0_q;
   assign ovf[0] = 1'b0;

   // Ready seen by stage k's output: downstream accepts, or some later stage is empty.
   always_comb begin
      logic rdy_acc;
      dn_rdy  = '0;
      rdy_acc = bus.out_ready;
      for (int k = NOPS; k >= 0; k--) begin
         dn_rdy[k] = rdy_acc;
         rdy_acc   = rdy_acc | ~vld[k];
      end
   end

   assign in_ready = !v0_q || dn_rdy[0];

   for (genvar k = 1; k <= NOPS; k++) begin : g_stage
      sdp_addsub_stage #(
         .W        (W),
         .NOPS     (NOPS),
         .SATURATE (SATURATE)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (vld[k-1]),
         .in_ready  (up_rdy[k]),
         .in_acc    (acc[k-1]),
         .in_ops    (ops[k-1]),
         .in_ctl    (ctl[k-1]),
         .in_ovf    (ovf[k-1]),
         .out_valid (vld[k]),
         .out_ready (dn_rdy[k]),
         .out_acc   (acc[k]),
         .out_ops   (ops[k]),
         .out_ctl   (ctl[k]),
         .out_ovf   (ovf[k])
      );
   end

   assign unused_tail = ^{ops[NOPS], ctl[NOPS], up_rdy};

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = vld[NOPS];
   assign bus.out_data  = acc[NOPS];
   assign bus.out_ovf   = ovf[NOPS];
endmodule

// File: tb/tb_sdp_addsub_pipe.sv
// Bench for sdp_addsub_pipe: wrap and saturate W=8 instances share stimulus, plus a W=1 instance.
module tb_sdp_addsub_pipe;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        v8, r8;
   logic [7:0]  a8;
   logic [15:0] ops8;
   logic [1:0]  ctl8;
   logic        v1, r1, a1;
   logic [1:0]  ops1, ctl1;

   sdp_addsub_pipe_if #(.W(8), .NOPS(2)) ifw ();
   sdp_addsub_pipe_if #(.W(8), .NOPS(2)) ifs ();
   sdp_addsub_pipe_if #(.W(1), .NOPS(2)) if1 ();

   assign ifw.in_valid = v8;  assign ifw.out_ready = r8;  assign ifw.in_a = a8;
   assign ifw.in_ops = ops8;  assign ifw.in_ctl = ctl8;
   assign ifs.in_valid = v8;  assign ifs.out_ready = r8;  assign ifs.in_a = a8;
   assign ifs.in_ops = ops8;  assign ifs.in_ctl = ctl8;
   assign if1.in_valid = v1;  assign if1.out_ready = r1;  assign if1.in_a = a1;
   assign if1.in_ops = ops1;  assign if1.in_ctl = ctl1;

   sdp_addsub_pipe #(.W(8), .NOPS(2), .SATURATE(1'b0)) u_wrap (.clk(clk), .reset(reset), .bus(ifw));
   sdp_addsub_pipe #(.W(8), .NOPS(2), .SATURATE(1'b1)) u_sat  (.clk(clk), .reset(reset), .bus(ifs));
   sdp_addsub_pipe #(.W(1), .NOPS(2), .SATURATE(1'b0)) u_w1   (.clk(clk), .reset(reset), .bus(if1));

   typedef struct {
      logic [7:0] data;
      logic       ovf;
      int         cyc;
   } exp_t;

   exp_t       qw[$], qs[$], q1[$];
   int         n_assert = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   bit         check_lat;
   bit         dir_en;
   logic [8:0] dir_w, dir_s;
   bit         last_acc_w;

   // Signed arithmetic on plain integers, stage by stage; returns {ovf, data}.
   function automatic logic [8:0] ref_calc(int w, bit sat, int a, int op0, int op1,
                                           logic [1:0] ctl);
      int hi = (1 << (w - 1)) - 1;
      int lo = -(1 << (w - 1));
      int opv[2];
      int acc, t, o;
      bit ovf = 1'b0;
      logic [8:0] r;
      opv[0] = op0;
      opv[1] = op1;
      acc = (a > hi) ? a - (1 << w) : a;
      for (int k = 0; k < 2; k++) begin
         o = (opv[k] > hi) ? opv[k] - (1 << w) : opv[k];
         t = ctl[k] ? acc + o : acc - o;
         if (t > hi || t < lo) begin
            ovf = 1'b1;
            if (sat) t = (t > hi) ? hi : lo;
            else     t = (t > hi) ? t - (1 << w) : t + (1 << w);
         end
         acc = t;
      end
      r[8]   = ovf;
      r[7:0] = 8'(acc & ((1 << w) - 1));
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(string tag, logic v, logic rdy, logic [7:0] d, logic o,
                            inout exp_t q[$], input bit lat);
      exp_t e;
      if (v && rdy) begin
         if (q.size() == 0) begin
            chk({tag, "_unexpected_out"}, 32'(v), 32'd0);
         end else begin
            e = q.pop_front();
            chk({tag, "_data"}, 32'(d), 32'(e.data));
            chk({tag, "_ovf"}, 32'(o), 32'(e.ovf));
            if (lat) chk({tag, "_latency"}, 32'(cyc - e.cyc), 32'd3);
         end
      end
   endtask

   // Samples handshakes just before the posedge, then advances to the next negedge.
   task automatic tick();
      exp_t       e;
      logic [8:0] m;
      #1;
      last_acc_w = 1'b0;
      if (!reset) begin
         check_out("wrap", ifw.out_valid, ifw.out_ready, ifw.out_data, ifw.out_ovf, qw, check_lat);
         check_out("sat", ifs.out_valid, ifs.out_ready, ifs.out_data, ifs.out_ovf, qs, check_lat);
         check_out("w1", if1.out_valid, if1.out_ready, {7'd0, if1.out_data}, if1.out_ovf, q1,
                   1'b1);
         e.cyc = cyc;
         if (ifw.in_valid && ifw.in_ready) begin
            last_acc_w = 1'b1;
            m = dir_en ? dir_w : ref_calc(8, 1'b0, a8, ops8[7:0], ops8[15:8], ctl8);
            e.ovf = m[8]; e.data = m[7:0];
            qw.push_back(e);
         end
         if (ifs.in_valid && ifs.in_ready) begin
            m = dir_en ? dir_s : ref_calc(8, 1'b1, a8, ops8[7:0], ops8[15:8], ctl8);
            e.ovf = m[8]; e.data = m[7:0];
            qs.push_back(e);
         end
         if (if1.in_valid && if1.in_ready) begin
            m = ref_calc(1, 1'b0, a1, ops1[0], ops1[1], ctl1);
            e.ovf = m[8]; e.data = m[7:0];
            q1.push_back(e);
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send8(logic [7:0] a, logic [7:0] op0, logic [7:0] op1, logic [1:0] ctl,
                        logic [8:0] ew, logic [8:0] es);
      v8 = 1'b1; a8 = a; ops8 = {op1, op0}; ctl8 = ctl;
      dir_en = 1'b1; dir_w = ew; dir_s = es;
      tick();
      v8 = 1'b0; dir_en = 1'b0;
   endtask

   task automatic clear_q();
      qw.delete(); qs.delete(); q1.delete();
   endtask

   initial begin
      int         n_acc;
      logic [7:0] held;
      reset = 1'b1; v8 = 1'b0; r8 = 1'b1; a8 = '0; ops8 = '0; ctl8 = '0;
      v1 = 1'b0; r1 = 1'b1; a1 = 1'b0; ops1 = '0; ctl1 = '0;
      dir_en = 1'b0; dir_w = '0; dir_s = '0; check_lat = 1'b1;
      @(negedge clk);
      idle(2);
      reset = 1'b0;
      clear_q();

      chk("rst_wrap_out_valid", 32'(ifw.out_valid), 32'd0);
      chk("rst_wrap_out_data", 32'(ifw.out_data), 32'd0);
      chk("rst_wrap_out_ovf", 32'(ifw.out_ovf), 32'd0);
      chk("rst_wrap_in_ready", 32'(ifw.in_ready), 32'd1);
      chk("rst_sat_out_valid", 32'(ifs.out_valid), 32'd0);
      chk("rst_sat_in_ready", 32'(ifs.in_ready), 32'd1);

      // Directed vectors: {ovf, data} for wrap and saturate instances.
      send8(8'd5, 8'd3, 8'd2, 2'b01, {1'b0, 8'd6}, {1'b0, 8'd6});
      idle(4);
      chk("basic_wrap_drained", 32'(qw.size()), 32'd0);
      send8(8'd127, 8'd1, 8'd0, 2'b11, {1'b1, 8'h80}, {1'b1, 8'h7F});
      send8(8'h80, 8'd1, 8'd0, 2'b00, {1'b1, 8'h7F}, {1'b1, 8'h80});
      send8(8'd127, 8'd1, 8'd5, 2'b01, {1'b1, 8'd123}, {1'b1, 8'd122});
      idle(5);
      chk("dir_wrap_drained", 32'(qw.size()), 32'd0);
      chk("dir_sat_drained", 32'(qs.size()), 32'd0);

      // Backpressure: stall 6 cycles with continuous input.
      check_lat = 1'b0;
      r8 = 1'b0; v8 = 1'b1; a8 = 8'd10; ops8 = '0; ctl8 = 2'b11;
      n_acc = 0; held = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (last_acc_w) begin n_acc++; a8 = a8 + 8'd1; end
         if (i == 2) held = ifw.out_data;
         if (i > 2) chk("bp_stable_data", 32'(ifw.out_data), 32'(held));
      end
      chk("bp_accepts", 32'(n_acc), 32'd3);
      chk("bp_in_ready_low", 32'(ifw.in_ready), 32'd0);
      chk("bp_held_first", 32'(held), 32'd10);
      r8 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("bp_flow_valid", 32'(ifw.out_valid), 32'd1);
         tick();
         if (last_acc_w) a8 = a8 + 8'd1;
      end
      v8 = 1'b0;
      idle(6);
      chk("bp_drained", 32'(qw.size()), 32'd0);

      // Reset with three transactions in flight; input during reset must be dropped.
      r8 = 1'b0; v8 = 1'b1; a8 = 8'h55; ops8 = 16'h0102; ctl8 = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick();
         a8 = a8 + 8'd1;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0; v8 = 1'b0; r8 = 1'b1;
      clear_q();
      chk("mid_rst_out_valid", 32'(ifw.out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(ifw.out_data), 32'd0);
      chk("mid_rst_out_ovf", 32'(ifw.out_ovf), 32'd0);
      chk("mid_rst_in_ready", 32'(ifw.in_ready), 32'd1);
      chk("mid_rst_sat_out_valid", 32'(ifs.out_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mid_rst_no_stale", 32'(ifw.out_valid), 32'd0);
      end

      // Random traffic with random backpressure on both W=8 instances.
      for (int i = 0; i < 300; i++) begin
         v8 = ($urandom_range(3) != 0); r8 = ($urandom_range(3) != 0);
         a8 = 8'($urandom); ops8 = 16'($urandom); ctl8 = 2'($urandom);
         tick();
      end
      v8 = 1'b0; r8 = 1'b1;
      for (int i = 0; i < 20 && (qw.size() != 0 || qs.size() != 0); i++) tick();
      chk("rand_wrap_drained", 32'(qw.size()), 32'd0);
      chk("rand_sat_drained", 32'(qs.size()), 32'd0);

      // W=1 regression, full throughput.
      v1 = 1'b1; r1 = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         a1 = 1'($urandom); ops1 = 2'($urandom); ctl1 = 2'($urandom);
         tick();
         if (i >= 3) chk("w1_out_valid", 32'(if1.out_valid), 32'd1);
      end
      v1 = 1'b0;
      idle(5);
      chk("w1_drained", 32'(q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
